razor_section_monitor: RTL and testbench

- Parametrised Razor error-recovery and error-rate controller for one FPTD section.
- Each channel is one section metric register: alpha, beta or be1. Defaults cover 7 alpha + 7 beta + 1 be1 = 15 channels.
- Per channel, compares the main flip-flop sample against the Razor shadow sample, substitutes the shadow value on mismatch, flags the error to the neighbouring section, and stalls on neighbour errors.
- Adds a windowed error counter with supply-voltage up/down requests and a sticky failure flag for persistent errors.

---
 rtl/razor_section_monitor.sv | 176 +++++++++++++++++
 tb/tb_razor_section_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/razor_section_monitor.sv
// Razor error-recovery and error-rate controller for one FPTD section.
// Each channel compares its main sample against the Razor shadow sample,
// substitutes the shadow value on mismatch and signals the neighbour.
// Errors are counted per window to request supply adjustments, and a
// run of consecutive erroneous cycles latches a sticky failure flag.
module razor_section_monitor #(
    parameter int unsigned C          = 15,
    parameter int unsigned W          = 5,
    parameter int unsigned WINDOW     = 16,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ERR_HI     = 4,
    parameter int unsigned ERR_LO     = 0,
    parameter int unsigned MAX_CONSEC = 3
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Enable,
    input  logic [C*W-1:0]   main_d,
    input  logic [C*W-1:0]   shadow_d,
    input  logic [C-1:0]     Error_previous,
    output logic [C*W-1:0]   q,
    output logic [C-1:0]     Error_current,
    output logic             any_error,
    output logic [CNT_W-1:0] last_count,
    output logic             window_done,
    output logic             vdd_up,
    output logic             vdd_down,
    output logic             fail
);

    localparam int unsigned WC_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned E_W   = $clog2(C + 1);
    localparam int unsigned SUM_W = ((CNT_W > E_W) ? CNT_W : E_W) + 1;
    localparam int unsigned CS_W  = $clog2(MAX_CONSEC + 1);
    localparam logic [SUM_W-1:0] CNT_MAX  = SUM_W'({CNT_W{1'b1}});
    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);
    localparam bit FAIL_ON_FIRST = (MAX_CONSEC <= 1);

    typedef enum logic [1:0] {
        ST_OK,
        ST_CONSEC,
        ST_FAILED
    } state_t;

    state_t           state, state_next;
    logic [CS_W-1:0]  consec, consec_next;

    logic [C*W-1:0]   q_next;
    logic [C-1:0]     err_next;
    logic [E_W-1:0]   e_cnt;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] running;
    logic [WC_W-1:0]  wcnt;
    logic             window_close;

    // Per-channel correction: neighbour stall wins over local mismatch.
    always_comb begin
        q_next   = q;
        err_next = '0;
        if (Enable) begin
            for (int unsigned c = 0; c < C; c++) begin
                if (Error_previous[c]) begin
                    q_next[c*W +: W] = q[c*W +: W];
                end else if (main_d[c*W +: W] != shadow_d[c*W +: W]) begin
                    q_next[c*W +: W] = shadow_d[c*W +: W];
                    err_next[c]      = 1'b1;
                end else begin
                    q_next[c*W +: W] = main_d[c*W +: W];
                end
            end
        end
    end

    // Number of channels flagged on the coming edge.
    always_comb begin
        e_cnt = '0;
        for (int unsigned c = 0; c < C; c++) begin
            e_cnt = e_cnt + E_W'(err_next[c]);
        end
    end

    // Saturating running total including this cycle's errors.
    always_comb begin
        sum          = SUM_W'(running) + SUM_W'(e_cnt);
        total        = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
        window_close = Enable && (wcnt == WIN_LAST);
    end

    // Channel value and error registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            q             <= '0;
            Error_current <= '0;
        end else begin
            q             <= q_next;
            Error_current <= err_next;
        end
    end

    // Window counter, running total and supply-request pulses.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wcnt        <= '0;
            running     <= '0;
            last_count  <= '0;
            window_done <= 1'b0;
            vdd_up      <= 1'b0;
            vdd_down    <= 1'b0;
        end else begin
            window_done <= 1'b0;
            vdd_up      <= 1'b0;
            vdd_down    <= 1'b0;
            if (window_close) begin
                last_count  <= total;
                running     <= '0;
                wcnt        <= '0;
                window_done <= 1'b1;
                vdd_up      <= (total > CNT_W'(ERR_HI)) || fail;
                vdd_down    <= (total <= CNT_W'(ERR_LO)) && !fail;
            end else if (Enable) begin
                running <= total;
                wcnt    <= wcnt + 1'b1;
            end
        end
    end

    // Consecutive-error state register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state  <= ST_OK;
            consec <= '0;
        end else begin
            state  <= state_next;
            consec <= consec_next;
        end
    end

    // Consecutive-error next state; FAILED is left only through reset.
    always_comb begin
        state_next  = state;
        consec_next = consec;
        if (Enable) begin
            case (state)
                ST_OK: begin
                    if (e_cnt != '0) begin
                        consec_next = CS_W'(1);
                        state_next  = FAIL_ON_FIRST ? ST_FAILED : ST_CONSEC;
                    end
                end
                ST_CONSEC: begin
                    if (e_cnt != '0) begin
                        consec_next = consec + 1'b1;
                        if (consec_next >= CS_W'(MAX_CONSEC)) begin
                            state_next = ST_FAILED;
                        end
                    end else begin
                        consec_next = '0;
                        state_next  = ST_OK;
                    end
                end
                ST_FAILED: begin
                    state_next = ST_FAILED;
                end
                default: begin
                    state_next  = ST_OK;
                    consec_next = '0;
                end
            endcase
        end
    end

    assign any_error = |Error_current;
    assign fail      = (state == ST_FAILED);

endmodule

// File: tb/tb_razor_section_monitor.sv
// Scoreboard bench for razor_section_monitor: the stimulus process pushes
// the expected post-edge outputs from an integer reference model, and a
// separate monitor pops and compares them one edge later.
module tb_razor_section_monitor;

    localparam int C          = 15;
    localparam int W          = 5;
    localparam int WINDOW     = 16;
    localparam int CNT_W      = 8;
    localparam int ERR_HI     = 4;
    localparam int ERR_LO     = 0;
    localparam int MAX_CONSEC = 3;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;

    logic             Clock;
    logic             nReset;
    logic             Enable;
    logic [C*W-1:0]   main_d;
    logic [C*W-1:0]   shadow_d;
    logic [C-1:0]     Error_previous;
    logic [C*W-1:0]   q;
    logic [C-1:0]     Error_current;
    logic             any_error;
    logic [CNT_W-1:0] last_count;
    logic             window_done;
    logic             vdd_up;
    logic             vdd_down;
    logic             fail;

    razor_section_monitor #(
        .C(C), .W(W), .WINDOW(WINDOW), .CNT_W(CNT_W),
        .ERR_HI(ERR_HI), .ERR_LO(ERR_LO), .MAX_CONSEC(MAX_CONSEC)
    ) dut (
        .Clock(Clock), .nReset(nReset), .Enable(Enable),
        .main_d(main_d), .shadow_d(shadow_d), .Error_previous(Error_previous),
        .q(q), .Error_current(Error_current), .any_error(any_error),
        .last_count(last_count), .window_done(window_done),
        .vdd_up(vdd_up), .vdd_down(vdd_down), .fail(fail)
    );

    typedef struct {
        logic [C*W-1:0]   q;
        logic [C-1:0]     err;
        logic             any;
        logic [CNT_W-1:0] last;
        logic             wd;
        logic             up;
        logic             down;
        logic             fl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, held as plain integers per channel.
    logic [W-1:0] m_q [C];
    int           m_running;
    int           m_wcnt;
    int           m_consec;
    int           m_last;
    bit           m_failed;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [C*W-1:0] act, input logic [C*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < C; c++) m_q[c] = '0;
        m_running = 0;
        m_wcnt    = 0;
        m_consec  = 0;
        m_last    = 0;
        m_failed  = 0;
    endtask

    task automatic model_step(input bit en, input logic [C*W-1:0] md, input logic [C*W-1:0] sd,
                              input logic [C-1:0] ep, output exp_t x);
        int e;
        int tot;
        e      = 0;
        x.err  = '0;
        x.wd   = 1'b0;
        x.up   = 1'b0;
        x.down = 1'b0;
        if (en) begin
            for (int c = 0; c < C; c++) begin
                if (ep[c]) begin
                    // stalled channel keeps its value
                end else if (md[c*W +: W] != sd[c*W +: W]) begin
                    m_q[c]   = sd[c*W +: W];
                    x.err[c] = 1'b1;
                    e++;
                end else begin
                    m_q[c] = md[c*W +: W];
                end
            end
            tot = m_running + e;
            if (tot > CNT_SAT) tot = CNT_SAT;
            if (m_wcnt == WINDOW - 1) begin
                m_last    = tot;
                m_running = 0;
                m_wcnt    = 0;
                x.wd      = 1'b1;
                x.up      = (tot > ERR_HI) || m_failed;
                x.down    = (tot <= ERR_LO) && !m_failed;
            end else begin
                m_running = tot;
                m_wcnt++;
            end
            if (!m_failed) begin
                if (e > 0) begin
                    m_consec++;
                    if (m_consec >= MAX_CONSEC) m_failed = 1;
                end else begin
                    m_consec = 0;
                end
            end
        end
        for (int c = 0; c < C; c++) x.q[c*W +: W] = m_q[c];
        x.any  = |x.err;
        x.last = CNT_W'(m_last);
        x.fl   = m_failed;
    endtask

    // Called at a falling edge: drive inputs, predict, advance one cycle.
    task automatic cycle(input bit en, input logic [C*W-1:0] md, input logic [C*W-1:0] sd,
                         input logic [C-1:0] ep);
        exp_t x;
        Enable         = en;
        main_d         = md;
        shadow_d       = sd;
        Error_previous = ep;
        model_step(en, md, sd, ep, x);
        sb.push_back(x);
        @(negedge Clock);
    endtask

    task automatic rand_cycle(input int en_pct, input int err_pct, input int prev_pct);
        logic [C*W-1:0] md;
        logic [C*W-1:0] sd;
        logic [C-1:0]   ep;
        logic [W-1:0]   flip;
        for (int c = 0; c < C; c++) begin
            md[c*W +: W] = W'($urandom);
            flip         = W'($urandom_range((1 << W) - 1, 1));
            sd[c*W +: W] = ($urandom_range(99) < err_pct) ? (md[c*W +: W] ^ flip) : md[c*W +: W];
            ep[c]        = ($urandom_range(99) < prev_pct);
        end
        cycle($urandom_range(99) < en_pct, md, sd, ep);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        Enable = 1'b0;
        #1;
        chk("rst_q", q, '0);
        chk("rst_err", C*W'(Error_current), '0);
        chk("rst_flags", C*W'({any_error, window_done, vdd_up, vdd_down, fail}), '0);
        chk("rst_last", C*W'(last_count), '0);
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    // Monitor: one expected entry is consumed per rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge Clock);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q", q, x.q);
                chk("Error_current", C*W'(Error_current), C*W'(x.err));
                chk("any_error", C*W'(any_error), C*W'(x.any));
                chk("last_count", C*W'(last_count), C*W'(x.last));
                chk("window_done", C*W'(window_done), C*W'(x.wd));
                chk("vdd_up", C*W'(vdd_up), C*W'(x.up));
                chk("vdd_down", C*W'(vdd_down), C*W'(x.down));
                chk("fail", C*W'(fail), C*W'(x.fl));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [C*W-1:0] md;
        logic [C*W-1:0] sd;
        logic [C-1:0]   ep;
        nReset         = 1'b0;
        Enable         = 1'b0;
        main_d         = '0;
        shadow_d       = '0;
        Error_previous = '0;
        model_reset();
        @(negedge Clock);
        do_reset();

        // Clean traffic over a full window: no errors, vdd_down at close.
        for (int i = 0; i < 18; i++) begin
            md = {$urandom, $urandom, $urandom};
            cycle(1'b1, md, md, '0);
        end

        // Channel 3 mismatch, then a clean cycle clears the flag.
        md = {$urandom, $urandom, $urandom};
        sd = md;
        md[3*W +: W] = 5'b10110;
        sd[3*W +: W] = 5'd9;
        cycle(1'b1, md, sd, '0);
        cycle(1'b1, md, md, '0);

        // Neighbour stall on channel 5 masks its local mismatch.
        md = {$urandom, $urandom, $urandom};
        sd = md;
        md[5*W +: W] = 5'd12;
        sd[5*W +: W] = 5'd2;
        ep = '0;
        ep[5] = 1'b1;
        cycle(1'b1, md, sd, ep);
        cycle(1'b1, md, md, '0);

        for (int i = 0; i < 40; i++) rand_cycle(90, 1, 5);

        // Enable low for five cycles with mismatches present.
        for (int i = 0; i < 5; i++) rand_cycle(0, 40, 10);
        for (int i = 0; i < 30; i++) rand_cycle(100, 0, 0);

        // Channels 0 and 1 mismatch on three consecutive enabled cycles.
        for (int i = 0; i < 3; i++) begin
            md = {$urandom, $urandom, $urandom};
            sd = md;
            sd[0 +: W] = ~md[0 +: W];
            sd[W +: W] = ~md[W +: W];
            cycle(1'b1, md, sd, '0);
        end
        for (int i = 0; i < 40; i++) rand_cycle(85, 0, 5);
        for (int i = 0; i < 30; i++) rand_cycle(85, 20, 10);

        // Reset mid-window after seven enabled cycles with errors.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            md = {$urandom, $urandom, $urandom};
            sd = md;
            sd[2*W +: W] = (i < 3) ? ~md[2*W +: W] : md[2*W +: W];
            cycle(1'b1, md, sd, '0);
        end
        do_reset();
        for (int i = 0; i < 20; i++) rand_cycle(100, 0, 0);

        // Mixed random traffic across error rates and resets.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 120; i++) rand_cycle(80, r, 8);
            do_reset();
        end
        for (int i = 0; i < 200; i++) rand_cycle(90, 2, 3);

        Enable = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
